matrix_alu_sequencer: RTL and testbench
=======================================

MATRIX_ALU_SEQUENCER -- requirements
Module: matrix_alu_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of the matrix memory address.
REQ-002 SHALL have parameter TMO_CYC, default 64: watchdog limit in cycles.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: command strobe, sampled only in IDLE.
REQ-006 SHALL have port opcode, input, 3: 001 ADD, 010 SUB, 011 SCALE, 100 TRANS, 101 MULTI.
REQ-007 SHALL have ports src1_addr, src2_addr and dst_addr, each input, ADDR_W: operand and result addresses.
REQ-008 SHALL have port scalar, input, 8: the SCALE factor.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have ports done and err, each output, 1: one-cycle completion and error pulses.
REQ-011 SHALL have ports mem_rd_en, mem_wr_en, output, 1, and mem_addr, output, ADDR_W: memory request.
REQ-012 SHALL have ports mem_rd_data, input, 256; mem_rd_valid, input, 1; mem_wr_data, output, 256.
REQ-013 SHALL have ports alu_load_m1 and alu_load_m2, output, 1; alu_loaded1 and alu_loaded2, input, 1: ALU load handshakes.
REQ-014 SHALL have ports alu_mat_in, output, 256; alu_mat_out, input, 256; alu_finish, input, 1.
REQ-015 SHALL have ports alu_op, output, 3, and alu_scale, output, 8.

Function
REQ-016 SHALL implement the states IDLE, RD1, LD1, RD2, LD2, EXEC, WR and FIN.
REQ-017 IDLE: on start=1 with a valid opcode, SHALL latch opcode, all three addresses and scalar, then enter RD1 the next cycle.
REQ-018 On start=1 with opcode 000, 110 or 111, SHALL pulse err for one cycle, stay in IDLE and make no memory access.
REQ-019 RD1: SHALL hold mem_rd_en=1 and mem_addr=src1_addr until mem_rd_valid, then capture mem_rd_data into a 256-bit holding register and go to LD1.
REQ-020 LD1: SHALL drive alu_mat_in from the holding register and hold alu_load_m1=1 until alu_loaded1=1.
REQ-021 On leaving LD1, SHALL go to RD2 for ADD, SUB and MULTI, and to EXEC for SCALE and TRANS (unary ops skip the second operand).
REQ-022 RD2 and LD2: SHALL behave as RD1 and LD1, using src2_addr, alu_load_m2 and alu_loaded2.
REQ-023 EXEC: SHALL drive alu_op with the latched opcode and alu_scale with the latched scalar; at alu_finish=1, SHALL capture alu_mat_out and go to WR.
REQ-024 Outside EXEC, SHALL hold alu_op=000; alu_scale SHALL hold its latched value.
REQ-025 WR: SHALL drive mem_wr_en=1 for exactly one cycle with mem_addr=dst_addr and mem_wr_data set to the captured result, then go to FIN.
REQ-026 FIN: SHALL pulse done=1 for one cycle and return to IDLE; the earliest restart is start sampled in the following IDLE cycle.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL never assert alu_load_m1 and alu_load_m2 in the same cycle.
REQ-029 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.
REQ-030 SHALL ignore mem_rd_valid outside RD1/RD2 and alu_finish outside EXEC.
REQ-031 Minimum latency for a binary op, with single-cycle memory and ALU responses, SHALL be 8 cycles from the start sample to the done pulse.

Reset
REQ-032 reset=1 SHALL force IDLE immediately, at any point in any state.
REQ-033 During reset, every output (busy, done, err, all mem_* and all alu_* outputs) SHALL be 0, and the holding and result registers SHALL be cleared.
REQ-034 A reset mid-operation SHALL abandon the command without any memory write and without a done or err pulse.

Configuration
REQ-035 With macro ALU_SEQ_TIMEOUT_EN defined, a counter SHALL run in RD1, LD1, RD2, LD2 and EXEC, clearing on every state change.
REQ-036 With ALU_SEQ_TIMEOUT_EN defined, when the counter reaches TMO_CYC the block SHALL deassert all requests, pulse err for one cycle and return to IDLE without writing.
REQ-037 Without ALU_SEQ_TIMEOUT_EN, no counter SHALL exist and the block SHALL wait indefinitely for every handshake.

Verification
REQ-038 ADD: src1 holds rows {5,8,9,2 / 7,3,8,4 / 6,5,4,3 / 8,5,7,6}, src2 holds {11,14,19,18 / 6,9,3,5 / 12,10,15,14 / 1,3,5,7}; ALU model responds in 1 cycle -> dst row0 = 16,22,28,20; one done pulse; two reads, one write.
REQ-039 TRANS on src1 -> no src2 read and no alu_load_m2; dst row0 = 5,7,6,8.
REQ-040 SCALE with scalar=5 on src1 -> alu_scale=5 during EXEC; dst row0 = 25,40,45,10.
REQ-041 start with opcode 111 -> err pulse on the next cycle; busy stays 0; no mem_rd_en.
REQ-042 reset pulsed during EXEC -> all outputs 0 at once; no mem_wr_en and no done; a new ADD afterwards completes normally.
REQ-043 With ALU_SEQ_TIMEOUT_EN, alu_finish never asserted -> err pulse after 64 EXEC cycles, return to IDLE, no write.

Source files
------------

// File: rtl/matrix_alu_sequencer.sv
// Sequences operand fetch, ALU load, execute and result write-back for 4x4 matrix ops.
// Optional watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module matrix_alu_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        scalar,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [255:0]      mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [255:0]      mem_wr_data,
  output logic              alu_load_m1,
  output logic              alu_load_m2,
  input  logic              alu_loaded1,
  input  logic              alu_loaded2,
  output logic [255:0]      alu_mat_in,
  input  logic [255:0]      alu_mat_out,
  input  logic              alu_finish,
  output logic [2:0]        alu_op,
  output logic [7:0]        alu_scale
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD1  = 3'd1;
  localparam logic [2:0] LD1  = 3'd2;
  localparam logic [2:0] RD2  = 3'd3;
  localparam logic [2:0] LD2  = 3'd4;
  localparam logic [2:0] EXEC = 3'd5;
  localparam logic [2:0] WR   = 3'd6;
  localparam logic [2:0] FIN  = 3'd7;

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_MULTI = 3'b101;
  localparam logic [2:0] OP_SCALE = 3'b011;
  localparam logic [2:0] OP_TRANS = 3'b100;

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
  logic [7:0]        scalar_q;
  logic [255:0]      hold_q;
  logic [255:0]      res_q;
  logic              err_q;
  logic              op_valid;
  logic              op_unary;
  logic              tmo_hit;

  assign op_valid = (opcode >= OP_ADD) && (opcode <= OP_MULTI);
  assign op_unary = (op_q == OP_SCALE) || (op_q == OP_TRANS);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && op_valid) state_d = RD1;
      RD1:  if (mem_rd_valid) state_d = LD1;
      LD1:  if (alu_loaded1) state_d = op_unary ? EXEC : RD2;
      RD2:  if (mem_rd_valid) state_d = LD2;
      LD2:  if (alu_loaded2) state_d = EXEC;
      EXEC: if (alu_finish) state_d = WR;
      WR:   state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Watchdog abandons the command; it overrides any same-cycle handshake.
    if (tmo_hit) state_d = IDLE;
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timed;

  assign timed   = (state_q == RD1) || (state_q == LD1) || (state_q == RD2) ||
                   (state_q == LD2) || (state_q == EXEC);
  assign tmo_hit = timed && (cnt_q == CNT_W'(TMO_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!timed || (state_d != state_q)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 3'b000;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      scalar_q <= 8'd0;
      hold_q   <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= tmo_hit;
      if ((state_q == IDLE) && start) begin
        if (op_valid) begin
          op_q     <= opcode;
          src1_q   <= src1_addr;
          src2_q   <= src2_addr;
          dst_q    <= dst_addr;
          scalar_q <= scalar;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (((state_q == RD1) || (state_q == RD2)) && mem_rd_valid) begin
        hold_q <= mem_rd_data;
      end
      if ((state_q == EXEC) && alu_finish) begin
        res_q <= alu_mat_out;
      end
    end
  end

  // Outputs decode straight from the state register, so reset zeroes them at once.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);
    err         = err_q;
    mem_rd_en   = (state_q == RD1) || (state_q == RD2);
    mem_wr_en   = (state_q == WR);
    mem_addr    = '0;
    mem_wr_data = '0;
    alu_load_m1 = (state_q == LD1);
    alu_load_m2 = (state_q == LD2);
    alu_mat_in  = '0;
    alu_op      = 3'b000;
    alu_scale   = scalar_q;
    unique case (state_q)
      RD1:  mem_addr = src1_q;
      RD2:  mem_addr = src2_q;
      LD1:  alu_mat_in = hold_q;
      LD2:  alu_mat_in = hold_q;
      EXEC: alu_op = op_q;
      WR: begin
        mem_addr    = dst_q;
        mem_wr_data = res_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Directed bench for matrix_alu_sequencer with a zero-wait memory and a behavioural ALU.
module tb_matrix_alu_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   opcode;
  logic [7:0]   src1_addr, src2_addr, dst_addr, scalar;
  logic         busy, done, err;
  logic         mem_rd_en, mem_wr_en;
  logic [7:0]   mem_addr;
  logic [255:0] mem_rd_data, mem_wr_data;
  logic         mem_rd_valid;
  logic         alu_load_m1, alu_load_m2, alu_loaded1, alu_loaded2;
  logic [255:0] alu_mat_in, alu_mat_out;
  logic         alu_finish;
  logic [2:0]   alu_op;
  logic [7:0]   alu_scale;
  bit           hang;

  int tests  = 0;
  int failed = 0;

  // Element (r,c) lives at bits [(r*4+c)*16 +: 16].
  localparam logic [255:0] S1 = {16'd6, 16'd7, 16'd5, 16'd8,  16'd3, 16'd4, 16'd5, 16'd6,
                                 16'd4, 16'd8, 16'd3, 16'd7,  16'd2, 16'd9, 16'd8, 16'd5};
  localparam logic [255:0] S2 = {16'd7, 16'd5, 16'd3, 16'd1,  16'd14, 16'd15, 16'd10, 16'd12,
                                 16'd5, 16'd3, 16'd9, 16'd6,  16'd18, 16'd19, 16'd14, 16'd11};

  matrix_alu_sequencer #(.ADDR_W(8), .TMO_CYC(64)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr), .scalar(scalar),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_wr_data(mem_wr_data),
    .alu_load_m1(alu_load_m1), .alu_load_m2(alu_load_m2),
    .alu_loaded1(alu_loaded1), .alu_loaded2(alu_loaded2),
    .alu_mat_in(alu_mat_in), .alu_mat_out(alu_mat_out), .alu_finish(alu_finish),
    .alu_op(alu_op), .alu_scale(alu_scale)
  );

  always #5 clk = ~clk;

  // Memory: reset reloads operands; reads answer in the same cycle.
  logic [255:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= S1;
      mem[8'h20] <= S2;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
  end
  assign mem_rd_data  = mem[mem_addr];
  assign mem_rd_valid = mem_rd_en;

  // ALU model
  logic [255:0] m1, m2;
  assign alu_loaded1 = alu_load_m1;
  assign alu_loaded2 = alu_load_m2;
  assign alu_finish  = (alu_op != 3'b000) && !hang;
  always @(posedge clk) begin
    if (alu_load_m1 && alu_loaded1) m1 <= alu_mat_in;
    if (alu_load_m2 && alu_loaded2) m2 <= alu_mat_in;
  end

  function automatic logic [15:0] el(input logic [255:0] m, input int r, input int c);
    return m[(r*4+c)*16 +: 16];
  endfunction

  function automatic logic [15:0] alu_el(input logic [2:0] op, input logic [7:0] sc,
                                         input logic [255:0] a, input logic [255:0] b,
                                         input int r, input int c);
    logic [15:0] acc;
    acc = '0;
    case (op)
      3'b001: acc = el(a, r, c) + el(b, r, c);
      3'b010: acc = el(a, r, c) - el(b, r, c);
      3'b011: acc = el(a, r, c) * {8'd0, sc};
      3'b100: acc = el(a, c, r);
      3'b101: for (int k = 0; k < 4; k++) acc = acc + el(a, r, k) * el(b, k, c);
      default: acc = '0;
    endcase
    return acc;
  endfunction

  always_comb begin
    alu_mat_out = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        alu_mat_out[(r*4+c)*16 +: 16] = alu_el(alu_op, alu_scale, m1, m2, r, c);
  end

  // Event monitors
  int rd_cnt = 0, wr_cnt = 0, m2_cnt = 0, done_cnt = 0, err_cnt = 0, exec_cnt = 0, viol = 0;
  logic [7:0] exec_scale = 8'd0;
  always @(posedge clk) begin
    if (mem_rd_en && mem_rd_valid) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (alu_load_m2) m2_cnt <= m2_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (alu_op != 3'b000) begin
      exec_cnt   <= exec_cnt + 1;
      exec_scale <= alu_scale;
    end
    if ((alu_load_m1 && alu_load_m2) || (mem_rd_en && mem_wr_en)) viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [575:0] outs();
    return {38'd0, busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
            alu_load_m1, alu_load_m2, alu_mat_in, alu_op, alu_scale};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [7:0] d, input logic [7:0] sc,
                        output int cyc, output bit got_done, output bit got_err);
    @(negedge clk);
    start = 1'b1; opcode = op; src1_addr = a1; src2_addr = a2; dst_addr = d; scalar = sc;
    @(negedge clk);
    start = 1'b0; opcode = 3'b000;
    cyc = 1;
    while (!done && !err && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    got_done = done;
    got_err  = err;
    @(negedge clk);
  endtask

  int  cyc, rd0, wr0, m20, dn0, er0, ex0;
  bit  gd, ge;

  task automatic snap();
    rd0 = rd_cnt; wr0 = wr_cnt; m20 = m2_cnt; dn0 = done_cnt; er0 = err_cnt; ex0 = exec_cnt;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 3'b000; hang = 1'b0;
    src1_addr = 8'h00; src2_addr = 8'h00; dst_addr = 8'h00; scalar = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), '0);
    reset = 1'b0;

    // ADD
    snap();
    run_op(3'b001, 8'h10, 8'h20, 8'h30, 8'd0, cyc, gd, ge);
    check("add_done", {575'd0, gd}, 576'd1);
    // done seen 7 cycles after the sampling edge: 8 cycles counting the sampling cycle
    check("add_latency", 576'(cyc + 1), 576'd8);
    check("add_row0", {512'd0, mem[8'h30][63:0]}, {512'd0, 16'd20, 16'd28, 16'd22, 16'd16});
    check("add_row3", {512'd0, mem[8'h30][255:192]}, {512'd0, 16'd13, 16'd12, 16'd8, 16'd9});
    check("add_reads", 576'(rd_cnt - rd0), 576'd2);
    check("add_writes", 576'(wr_cnt - wr0), 576'd1);
    check("add_dones", 576'(done_cnt - dn0), 576'd1);
    check("add_idle", {575'd0, busy}, 576'd0);

    // TRANS
    snap();
    run_op(3'b100, 8'h10, 8'h20, 8'h31, 8'd0, cyc, gd, ge);
    check("trans_row0", {512'd0, mem[8'h31][63:0]}, {512'd0, 16'd8, 16'd6, 16'd7, 16'd5});
    check("trans_reads", 576'(rd_cnt - rd0), 576'd1);
    check("trans_no_m2", 576'(m2_cnt - m20), 576'd0);

    // SCALE
    snap();
    run_op(3'b011, 8'h10, 8'h20, 8'h32, 8'd5, cyc, gd, ge);
    check("scale_alu_scale", {568'd0, exec_scale}, 576'd5);
    check("scale_row0", {512'd0, mem[8'h32][63:0]}, {512'd0, 16'd10, 16'd45, 16'd40, 16'd25});

    // SUB (src2 - src1)
    run_op(3'b010, 8'h20, 8'h10, 8'h33, 8'd0, cyc, gd, ge);
    check("sub_row0", {512'd0, mem[8'h33][63:0]}, {512'd0, 16'd16, 16'd10, 16'd6, 16'd6});

    // MULTI
    run_op(3'b101, 8'h10, 8'h20, 8'h36, 8'd0, cyc, gd, ge);
    check("multi_row0", {512'd0, mem[8'h36][63:0]}, {512'd0, 16'd270, 16'd264, 16'd238, 16'd213});

    // Illegal opcode
    snap();
    @(negedge clk);
    start = 1'b1; opcode = 3'b111;
    @(negedge clk);
    start = 1'b0; opcode = 3'b000;
    check("bad_err_pulse", {574'd0, err, busy}, 576'd2);
    @(negedge clk);
    check("bad_err_clear", {575'd0, err}, 576'd0);
    check("bad_no_read", 576'(rd_cnt - rd0), 576'd0);
    check("bad_err_count", 576'(err_cnt - er0), 576'd1);

    // Reset during EXEC, with an illegal start ignored while busy
    hang = 1'b1;
    snap();
    @(negedge clk);
    start = 1'b1; opcode = 3'b001; src1_addr = 8'h10; src2_addr = 8'h20; dst_addr = 8'h34;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (alu_op == 3'b000 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_exec", {573'd0, alu_op}, 576'd1);
    start = 1'b1; opcode = 3'b111;
    @(negedge clk);
    start = 1'b0; opcode = 3'b000;
    @(negedge clk);
    check("busy_start_ignored", {574'd0, err, busy}, 576'd1);
    #1 reset = 1'b1;
    #1 check("rst_async_outputs", outs(), '0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_no_write", 576'(wr_cnt - wr0), 576'd0);
    check("rst_no_done_err", 576'((done_cnt - dn0) + (err_cnt - er0)), 576'd0);
    hang = 1'b0;
    run_op(3'b001, 8'h10, 8'h20, 8'h35, 8'd0, cyc, gd, ge);
    check("post_rst_add_row0", {512'd0, mem[8'h35][63:0]},
          {512'd0, 16'd20, 16'd28, 16'd22, 16'd16});

    // ALU never finishes
    hang = 1'b1;
    snap();
    run_op(3'b011, 8'h10, 8'h20, 8'h37, 8'd3, cyc, gd, ge);
`ifdef ALU_SEQ_TIMEOUT_EN
    check("tmo_err", {574'd0, ge, gd}, 576'd2);
    check("tmo_exec_cycles", 576'(exec_cnt - ex0), 576'd64);
    check("tmo_idle", {575'd0, busy}, 576'd0);
    check("tmo_no_write", 576'(wr_cnt - wr0), 576'd0);
`else
    check("hang_waits", {573'd0, busy, ge, gd}, 576'd4);
    check("hang_still_exec", {573'd0, alu_op}, 576'd3);
    check("hang_no_write", 576'(wr_cnt - wr0), 576'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    hang = 1'b0;
    check("exclusive_requests", 576'(viol), 576'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
